// File: rtl/axi_ram_slave.sv
// AXI4 burst RAM slave: independent write (AW/W/B) and read (AR/R) engines sharing one
// word-wide memory with byte-lane write enables. Supports FIXED and INCR bursts; other burst codes error.
module axi_ram_slave #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // write address
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  // write response
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  // read address
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  // read data
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  // Handshake rule on every channel: a transfer happens on a rising edge where valid and
  // ready are both 1; a source holds valid and its payload stable until that edge.

  localparam int LANE_BITS = $clog2(STRB_WIDTH);
  localparam int WORD_BITS = ADDR_WIDTH - LANE_BITS;
  localparam int DEPTH     = 1 << WORD_BITS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRB_WIDTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // write engine state
  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [ID_WIDTH-1:0]   w_id;
  logic                  w_fixed;
  logic                  w_bad;
  logic                  w_err;

  // read engine state; r_addr always points at the beat to load next
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic                  r_fixed;
  logic                  r_bad;

  logic                  w_beat;
  logic                  w_final;
  logic                  w_err_nxt;
  logic                  mem_we;
  logic [WORD_BITS-1:0]  w_word;
  logic [WORD_BITS-1:0]  ar_word;
  logic [WORD_BITS-1:0]  r_word;

  assign w_beat    = s_axi_wvalid && s_axi_wready;
  assign w_final   = (w_cnt == w_len);
  assign w_err_nxt = w_err || (s_axi_wlast != w_final);
  assign mem_we    = rst_n && w_beat && !w_bad;
  assign w_word    = w_addr[ADDR_WIDTH-1:LANE_BITS];
  assign ar_word   = s_axi_araddr[ADDR_WIDTH-1:LANE_BITS];
  assign r_word    = r_addr[ADDR_WIDTH-1:LANE_BITS];

  // Storage is never reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) mem[w_word][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  // Burst length alone ends the burst; wlast is only checked, never obeyed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_id          <= '0;
      w_fixed       <= 1'b0;
      w_bad         <= 1'b0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            w_id          <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_cnt         <= '0;
            w_fixed       <= (s_axi_awburst == BURST_FIXED);
            w_bad         <= s_axi_awburst[1];
            w_err         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            s_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_err <= w_err_nxt;
            w_cnt <= w_cnt + 8'd1;
            if (!w_fixed) w_addr <= w_addr + ADDR_STEP;
            if (w_final) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id;
              s_axi_bresp  <= (w_err_nxt || w_bad) ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          // awready returns one cycle after the B handshake.
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: begin
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b0;
          s_axi_bvalid  <= 1'b0;
          w_state       <= W_IDLE;
        end
      endcase
    end
  end

  // Memory reads here see the value before any same-edge write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_fixed       <= 1'b0;
      r_bad         <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rid     <= s_axi_arid;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rresp   <= s_axi_arburst[1] ? RESP_SLVERR : RESP_OKAY;
            s_axi_rdata   <= s_axi_arburst[1] ? '0 : mem[ar_word];
            r_len         <= s_axi_arlen;
            r_cnt         <= '0;
            r_fixed       <= (s_axi_arburst == BURST_FIXED);
            r_bad         <= s_axi_arburst[1];
            r_addr        <= (s_axi_arburst == BURST_FIXED) ? s_axi_araddr
                                                            : s_axi_araddr + ADDR_STEP;
            r_state       <= R_DATA;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rvalid && s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              s_axi_rdata <= r_bad ? '0 : mem[r_word];
              s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
              r_cnt       <= r_cnt + 8'd1;
              if (!r_fixed) r_addr <= r_addr + ADDR_STEP;
            end
          end
        end
        default: begin
          s_axi_arready <= 1'b0;
          s_axi_rvalid  <= 1'b0;
          s_axi_rlast   <= 1'b0;
          r_state       <= R_IDLE;
        end
      endcase
    end
  end

endmodule
